// File: rtl/inv_key_expansion_control_if.sv
// Byte bus between the inverse AES-128 key schedule and its user.
// Optional INV_KEY_READY_EN adds key_out_ready for output backpressure.
interface inv_key_expansion_control_if;
    logic       load_key;
    logic [7:0] key_in;
    logic [7:0] key_out;
    logic       key_out_valid;
    logic [3:0] round;
    logic       busy;
    logic       done;
`ifdef INV_KEY_READY_EN
    logic       key_out_ready;
`endif

    modport master (
`ifdef INV_KEY_READY_EN
        output key_out_ready,
`endif
        output load_key, key_in,
        input  key_out, key_out_valid, round, busy, done
    );

    modport slave (
`ifdef INV_KEY_READY_EN
        input  key_out_ready,
`endif
        input  load_key, key_in,
        output key_out, key_out_valid, round, busy, done
    );
endinterface

// File: rtl/inv_key_expansion_control.sv
// Byte-serial AES-128 inverse key schedule: loads the round-10 key, emits round keys 10..0.
// Define INV_KEY_READY_EN to make EMIT honour bus.key_out_ready.
module inv_key_expansion_control #(
    parameter int NR = 10
) (
    input logic clk,
    input logic rst,
    inv_key_expansion_control_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, EMIT, CALC, DONE} state_t;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t       state, next_state;
    logic [3:0]   cnt;
    logic [3:0]   round_q;
    logic [127:0] key_q;
    logic         emit_adv;
    logic [31:0]  w3_new, rot_w3, w0_next;
    logic [7:0]   sbox_in, sbox_out, rc;

    // Entry 0 sits in the top byte of the table.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX_TBL[{~a, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

`ifdef INV_KEY_READY_EN
    assign emit_adv = (state == EMIT) && bus.key_out_ready;
`else
    assign emit_adv = (state == EMIT);
`endif

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: every clocked process uses <= so all registers update from pre-edge values.
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        // NOTE: default first, so no path through this block leaves a signal unassigned (no latch).
        next_state = state;
        unique case (state)
            IDLE: if (bus.load_key) next_state = LOAD;
            LOAD: if (cnt == 4'd14) next_state = EMIT;
            EMIT: if (emit_adv && cnt == 4'd15) next_state = (round_q == 4'd0) ? DONE : CALC;
            CALC: if (cnt == 4'd3) next_state = EMIT;
            DONE: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.key_out_valid = (state == EMIT);
        bus.key_out       = (state == EMIT) ? key_q[127:120] : 8'h00;
        bus.round         = round_q;
        bus.busy          = (state != IDLE);
        bus.done          = (state == DONE);
    end

    // w3' is not registered until the end of CALC cycle 0, so that cycle uses it directly.
    always_comb begin
        w3_new  = (cnt == 4'd0) ? (key_q[31:0] ^ key_q[63:32]) : key_q[31:0];
        rot_w3  = {w3_new[23:0], w3_new[31:24]};
        w0_next = key_q[127:96];
        sbox_in = rot_w3[31:24];
        unique case (cnt[1:0])
            2'd0: sbox_in = rot_w3[31:24];
            2'd1: sbox_in = rot_w3[23:16];
            2'd2: sbox_in = rot_w3[15:8];
            2'd3: sbox_in = rot_w3[7:0];
        endcase
        sbox_out = sbox(sbox_in);
        rc       = (cnt[1:0] == 2'd0) ? rcon(round_q) : 8'h00;
        unique case (cnt[1:0])
            2'd0: w0_next[31:24] = key_q[127:120] ^ sbox_out ^ rc;
            2'd1: w0_next[23:16] = key_q[119:112] ^ sbox_out;
            2'd2: w0_next[15:8]  = key_q[111:104] ^ sbox_out;
            2'd3: w0_next[7:0]   = key_q[103:96]  ^ sbox_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 4'd0;
            round_q <= 4'd0;
            // NOTE: the key register is cleared so an aborted sequence leaves no key material behind.
            key_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (bus.load_key) begin
                        key_q   <= {key_q[119:0], bus.key_in};
                        round_q <= 4'(NR);
                    end
                end
                LOAD: begin
                    key_q <= {key_q[119:0], bus.key_in};
                    cnt   <= (cnt == 4'd14) ? 4'd0 : cnt + 4'd1;
                end
                EMIT: begin
                    // Rotating left returns the key to its original alignment after 16 bytes.
                    if (emit_adv) begin
                        key_q <= {key_q[119:0], key_q[127:120]};
                        cnt   <= cnt + 4'd1;
                    end
                end
                CALC: begin
                    key_q[127:96] <= w0_next;
                    if (cnt == 4'd0)
                        key_q[95:0] <= {key_q[95:64] ^ key_q[127:96],
                                        key_q[63:32] ^ key_q[95:64],
                                        key_q[31:0]  ^ key_q[63:32]};
                    if (cnt == 4'd3) begin
                        cnt     <= 4'd0;
                        round_q <= round_q - 4'd1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: cnt <= 4'd0;
            endcase
        end
    end
endmodule
